// File: rtl/alu_seq_pkg.sv
// Shared types and constants for alu_sequencer: command ops, FSM states,
// ALU function codes and the op -> funct mapping.
package alu_seq_pkg;

  localparam int W_DEF    = 11;
  localparam int DMAX_DEF = 999;

  localparam logic [3:0] ALU_FN_ADD = 4'd0;
  localparam logic [3:0] ALU_FN_SUB = 4'd1;
  localparam logic [3:0] ALU_FN_MUL = 4'd2;
  localparam logic [3:0] ALU_FN_NOT = 4'd3;
  localparam logic [3:0] ALU_FN_CMP = 4'd4;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3,
    OP_NOT = 3'd4, OP_TGT = 3'd5, OP_TLT = 3'd6, OP_TEQ = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2
  } state_e;

  // MOV bypasses the ALU, so its code only has to be harmless.
  function automatic logic [3:0] op_funct(op_e op);
    case (op)
      OP_ADD:                 return ALU_FN_ADD;
      OP_SUB:                 return ALU_FN_SUB;
      OP_MUL:                 return ALU_FN_MUL;
      OP_NOT:                 return ALU_FN_NOT;
      OP_TGT, OP_TLT, OP_TEQ: return ALU_FN_CMP;
      default:                return ALU_FN_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_acc_clamp.sv
// acc_clamp: combinational saturation of a W-bit result to [-DMAX, +DMAX],
// using the operand signs to pick the rail when the ALU overflowed.
module acc_clamp #(
  parameter int W    = 11,
  parameter int DMAX = 999
) (
  input  logic [W-1:0] value,
  input  logic         ovf,
  input  logic         sign0,
  input  logic         sign1,
  input  logic         is_mul,
  output logic [W-1:0] result,
  output logic         clamped
);

  localparam logic signed [W-1:0] PMAX = W'(DMAX);
  localparam logic signed [W-1:0] NMAX = -PMAX;

  logic signed [W-1:0] sval;
  logic                neg;

  assign sval = value;
  // Wrapped value is meaningless on overflow; the true sign comes from the inputs.
  assign neg  = is_mul ? (sign0 ^ sign1) : sign0;

  always_comb begin
    result  = value;
    clamped = 1'b0;
    if (ovf) begin
      result = neg ? NMAX : PMAX;
    end else if (sval > PMAX) begin
      result  = PMAX;
      clamped = 1'b1;
    end else if (sval < NMAX) begin
      result  = NMAX;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator execution unit driving an external W-bit ALU; one command per
// 3 cycles. Optional result saturation under macro ALU_SAT_EN.
import alu_seq_pkg::*;

module alu_sequencer #(
  parameter int W    = W_DEF,
  parameter int DMAX = DMAX_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_operand,
  output logic [W-1:0] alu_in0,
  output logic [W-1:0] alu_in1,
  output logic [3:0]   alu_funct,
  input  logic [W-1:0] alu_out,
  input  logic         alu_overflow,
  input  logic         alu_gr,
  input  logic         alu_le,
  input  logic         alu_eq,
  output logic [W-1:0] acc,
  output logic         flag_plus,
  output logic         flag_minus,
  output logic         rsp_valid,
  output logic         rsp_ovf,
  output logic         ovf_sticky
);

  state_e       state, state_nx;
  op_e          op_q;
  logic         is_arith;
  logic [W-1:0] raw_val, wb_val;
  logic         raw_ovf, wb_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
  end

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
  assign raw_val  = (op_q == OP_MOV) ? alu_in1 : alu_out;
  assign raw_ovf  = is_arith & alu_overflow;

`ifdef ALU_SAT_EN
  logic [W-1:0] sat_val;
  logic         sat_hit;
  logic         sat_sel;

  acc_clamp #(.W(W), .DMAX(DMAX)) u_clamp (
    .value   (raw_val),
    .ovf     (raw_ovf),
    .sign0   (alu_in0[W-1]),
    .sign1   (alu_in1[W-1]),
    .is_mul  (op_q == OP_MUL),
    .result  (sat_val),
    .clamped (sat_hit)
  );

  // NOT yields only 0 or 100, so it never needs the clamp.
  assign sat_sel = is_arith || (op_q == OP_MOV);
  assign wb_val  = sat_sel ? sat_val : raw_val;
  assign wb_ovf  = raw_ovf | (sat_sel & sat_hit);
`else
  assign wb_val  = raw_val;
  assign wb_ovf  = raw_ovf;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_in0    <= '0;
      alu_in1    <= '0;
      alu_funct  <= '0;
      op_q       <= OP_MOV;
      acc        <= '0;
      flag_plus  <= 1'b0;
      flag_minus <= 1'b0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        alu_in0   <= acc;
        alu_in1   <= cmd_operand;
        alu_funct <= op_funct(op_e'(cmd_op));
        op_q      <= op_e'(cmd_op);
      end
      if (state == ST_EXEC) begin
        rsp_ovf    <= wb_ovf;
        ovf_sticky <= ovf_sticky | wb_ovf;
        case (op_q)
          OP_TGT:  begin flag_plus <= alu_gr; flag_minus <= !alu_gr; end
          OP_TLT:  begin flag_plus <= alu_le; flag_minus <= !alu_le; end
          OP_TEQ:  begin flag_plus <= alu_eq; flag_minus <= !alu_eq; end
          default: acc <= wb_val;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed scenarios plus random
// commands checked against an integer-arithmetic reference model.
import alu_seq_pkg::*;

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [10:0] cmd_operand;
  logic [10:0] alu_in0, alu_in1, alu_out, acc;
  logic [3:0]  alu_funct;
  logic        alu_overflow, alu_gr, alu_le, alu_eq;
  logic        flag_plus, flag_minus, rsp_valid, rsp_ovf, ovf_sticky;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_acc = 0;
  bit m_fp = 0, m_fm = 0, m_sticky = 0;

  alu_sequencer #(.W(11), .DMAX(999)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_funct(alu_funct),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_gr(alu_gr), .alu_le(alu_le), .alu_eq(alu_eq),
    .acc(acc), .flag_plus(flag_plus), .flag_minus(flag_minus),
    .rsp_valid(rsp_valid), .rsp_ovf(rsp_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // behavioural 11-bit ALU
  int ta, tb, tf;
  always_comb begin
    ta = $signed(alu_in0);
    tb = $signed(alu_in1);
    case (alu_funct)
      ALU_FN_ADD: tf = ta + tb;
      ALU_FN_SUB: tf = ta - tb;
      ALU_FN_MUL: tf = ta * tb;
      ALU_FN_NOT: tf = (ta == 0) ? 100 : 0;
      default:    tf = 0;
    endcase
    alu_out      = tf[10:0];
    alu_overflow = (alu_funct == ALU_FN_ADD || alu_funct == ALU_FN_SUB ||
                    alu_funct == ALU_FN_MUL) && (tf > 1023 || tf < -1024);
    alu_gr = (ta > tb);
    alu_le = (ta < tb);
    alu_eq = (ta == tb);
  end

  function automatic int sx(input int v);
    int w;
    w = v & 32'h7FF;
    return (w >= 1024) ? w - 2048 : w;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_fp = 0; m_fm = 0; m_sticky = 0;
  endtask

  // One command; hold keeps cmd_valid high (with junk) through EXEC/DONE.
  task automatic cmd(input int op, input int val, input bit hold = 0);
    int full, r, prev;
    bit ovf;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_operand = 11'(val);
    while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready_wait", int'(n < 10), 1);
    @(posedge clk); #1;
    cmd_valid = hold; cmd_op = 3'($urandom); cmd_operand = 11'($urandom);
    prev = m_acc;
    chk("in0_e0", sx(int'(alu_in0)), prev);
    chk("in1_e0", sx(int'(alu_in1)), sx(val));
    chk("rsp_e0", int'(rsp_valid), 0);
    chk("rdy_e0", int'(cmd_ready), 0);

    ovf = 0;
    case (op)
      0: full = val;
      1: full = prev + val;
      2: full = prev - val;
      3: full = prev * val;
      4: full = (prev == 0) ? 100 : 0;
      default: full = prev;
    endcase
    if (op <= 3) begin
`ifdef ALU_SAT_EN
      if (full > 999)       begin r = 999;  ovf = 1; end
      else if (full < -999) begin r = -999; ovf = 1; end
      else                        r = full;
`else
      r = sx(full);
      ovf = (r != full);
`endif
      m_acc = r;
    end else if (op == 4) begin
      m_acc = full;
    end else begin
      m_fp = (op == 5) ? (prev > val) : (op == 6) ? (prev < val) : (prev == val);
      m_fm = !m_fp;
    end
    m_sticky |= ovf;

    @(posedge clk); #1;
    chk("rsp_e1", int'(rsp_valid), 1);
    chk("acc_e1", sx(int'(acc)), m_acc);
    chk("ovf_e1", int'(rsp_ovf), int'(ovf));
    chk("stk_e1", int'(ovf_sticky), int'(m_sticky));
    chk("fp_e1", int'(flag_plus), int'(m_fp));
    chk("fm_e1", int'(flag_minus), int'(m_fm));
    chk("in0_hold", sx(int'(alu_in0)), prev);
    chk("in1_hold", sx(int'(alu_in1)), sx(val));
    @(posedge clk); #1;
    chk("rsp_e2", int'(rsp_valid), 0);
    chk("rdy_e2", int'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_acc", int'(acc), 0);
    chk("rst_in0", int'(alu_in0), 0);
    chk("rst_in1", int'(alu_in1), 0);
    chk("rst_funct", int'(alu_funct), 0);
    chk("rst_flags", int'({flag_plus, flag_minus, rsp_valid, rsp_ovf, ovf_sticky}), 0);

    cmd(0, 200); cmd(1, 4);
    chk("acc_204", sx(int'(acc)), 204);
    cmd(0, 500); cmd(1, 550);
`ifdef ALU_SAT_EN
    chk("add_sat", sx(int'(acc)), 999);
`else
    chk("add_wrap", sx(int'(acc)), -998);
`endif
    cmd(0, -350); cmd(2, 900);
`ifdef ALU_SAT_EN
    chk("sub_sat", sx(int'(acc)), -999);
`else
    chk("sub_wrap", sx(int'(acc)), 798);
`endif
    cmd(0, 20); cmd(5, -3);
    chk("tgt_acc", sx(int'(acc)), 20);
    cmd(7, 20); cmd(6, 50); cmd(6, -50);
    cmd(0, 7); cmd(4, 0);
    chk("not1", int'(acc), 0);
    cmd(4, 0);
    chk("not2", int'(acc), 100);
    cmd(0, 40); cmd(3, -30);
    cmd(0, 999, 1); cmd(0, -999, 1); cmd(1, 1);

    for (int i = 0; i < 40; i++) begin
      int op, v;
      op = int'($urandom_range(0, 7));
      v  = ($urandom_range(0, 3) == 0) ? sx(int'($urandom)) : int'($urandom_range(0, 60)) - 30;
      cmd(op, v, bit'($urandom_range(0, 1)));
    end

    // reset during EXEC with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_operand = 11'd5;
    @(posedge clk); #1;
    chk("abort_acc_e0", int'(cmd_ready), 0);
    cmd_op = 3'd0; cmd_operand = 11'd3;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort_rsp", int'(rsp_valid), 0);
    chk("abort_acc", int'(acc), 0);
    chk("abort_stk", int'(ovf_sticky), 0);
    @(posedge clk); #1;
    chk("abort_rsp2", int'(rsp_valid), 0);
    chk("abort_in1", int'(alu_in1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pend_in1", int'(alu_in1), 3);
    chk("pend_rdy", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("pend_rsp", int'(rsp_valid), 1);
    chk("pend_acc", int'(acc), 3);
    @(posedge clk); #1;
    chk("pend_rsp_e2", int'(rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Accumulator execution unit that sits on the operand side of the 11-bit `alu`. It accepts one command at a time over a valid/ready handshake and drives `in0`/`in1`/`funct` from registers. It captures `out`, `overflow` and the compare flags one cycle later, and writes the result back to an accumulator or to the +/− condition flags, following Shenzhen-style `acc` semantics.

## Interface
Parameters:
- `W`, 11: datapath width; matches the ALU width.
- `DMAX`, 999: saturation magnitude, used only under `ALU_SAT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: unit can accept a command.
- `cmd_op` in 3: 0 MOV, 1 ADD, 2 SUB, 3 MUL, 4 NOT, 5 TGT, 6 TLT, 7 TEQ.
- `cmd_operand` in W: signed two's-complement operand.
- `alu_in0` out W: registered; carries `acc`.
- `alu_in1` out W: registered; carries the operand.
- `alu_funct` out 4: registered ALU function code.
- `alu_out` in W: ALU result.
- `alu_overflow` in 1: ALU overflow.
- `alu_gr`, `alu_le`, `alu_eq` in 1 each: ALU compare flags for `in0` vs `in1`, signed.
- `acc` out W: accumulator.
- `flag_plus`, `flag_minus` out 1 each: condition-enable flags.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_ovf` out 1: overflow flag for the completed command; valid only with `rsp_valid`.
- `ovf_sticky` out 1: OR of every `rsp_ovf` since reset.

## Operation
- States: IDLE, EXEC, DONE. Encoding lives in the package.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, register `alu_in0`←`acc`, `alu_in1`←`cmd_operand`, `alu_funct`←mapped code, and the op. Go to EXEC.
- EXEC:
  - `cmd_ready`=0.
  - ALU inputs are held stable.
  - At the end of the cycle, sample the ALU outputs and write back per the op (below). Go to DONE.
- DONE:
  - `rsp_valid`=1 for exactly this cycle; `cmd_ready`=0.
  - Go to IDLE.
- Write-back per op:
  - MOV: `acc`←operand, ALU ignored, `rsp_ovf`=0.
  - ADD/SUB/MUL: `acc`←`alu_out`, `rsp_ovf`←`alu_overflow`.
  - NOT: `acc`←`alu_out` (ALU NOT yields 0 for a nonzero input), `rsp_ovf`=0.
  - TGT: `flag_plus`←`alu_gr`, `flag_minus`←!`alu_gr`; `acc` unchanged.
  - TLT: `flag_plus`←`alu_le`, `flag_minus`←!`alu_le`; `acc` unchanged.
  - TEQ: `flag_plus`←`alu_eq`, `flag_minus`←!`alu_eq`; `acc` unchanged.
- Non-test ops leave the flags untouched.
- `ovf_sticky` sets on any `rsp_ovf`=1 and clears only on reset.
- Arithmetic is W-bit two's complement; no width growth.

## Timing
- Reset values:
  - state IDLE.
  - `acc`, `alu_in0`, `alu_in1`, `alu_funct` = 0.
  - `flag_plus`, `flag_minus`, `rsp_valid`, `rsp_ovf`, `ovf_sticky` = 0.
  - `cmd_ready`=1 immediately after deassertion.
- Command latency and throughput:
  - Accept at edge E0.
  - ALU inputs are valid from E0 through E1.
  - `acc` and flags update at E1.
  - `rsp_valid` is high between E1 and E2.
  - `cmd_ready` returns high after E2.
  - Throughput is one command per 3 cycles.
- Back-to-back commands: `cmd_valid` held high across DONE is accepted on the first IDLE edge and sees the updated `acc`.
- `cmd_operand` and `cmd_op` need only be stable at the accept edge.
- Asserting `reset_n` low during EXEC or DONE aborts the command immediately: all reset values apply, no write-back and no `rsp_valid`.

## Configuration
- `ALU_SAT_EN` defined:
  - The ADD/SUB/MUL/MOV result is clamped to [−DMAX, +DMAX].
  - On `alu_overflow`:
    - ADD and SUB clamp to the sign of `in0`.
    - MUL clamps to the sign of `in0` XOR the sign of `in1`.
  - A clamp of an in-range-W but out-of-DMAX value sets `rsp_ovf`=1.
- `ALU_SAT_EN` undefined: `acc` takes the raw wrapped `alu_out`; MOV stores the operand raw.

## Structure
- Shared package `alu_seq_pkg`:
  - `cmd_op` enum.
  - State enum.
  - op→funct mapping function, reusing the existing ALU funct constants.
  - `DMAX` default.
- One sub-module, `acc_clamp`:
  - Combinational saturation of a W-bit value given the overflow bit and the operand signs.
  - Instantiated only under `ALU_SAT_EN`.

## Test plan
- Reset, then MOV 200 then ADD 4:
  - `acc`=204, `rsp_ovf`=0.
  - `rsp_valid` exactly one cycle, 2 edges after each accept.
- MOV 500 then ADD 550:
  - `rsp_ovf`=1 and `ovf_sticky`=1.
  - `acc`=raw `alu_out`, or 999 with `ALU_SAT_EN`.
- MOV −350 then SUB 900:
  - `rsp_ovf`=1.
  - `acc`=−999 with `ALU_SAT_EN`.
- MOV 20 then TGT −3:
  - `flag_plus`=1, `flag_minus`=0, `acc` stays 20.
  - A following TEQ 20 gives `flag_plus`=1.
- MOV 7, then NOT, then NOT:
  - `acc`=0 after the first NOT.
  - `acc`=100 after the second NOT.
- With `cmd_valid` held high, assert `reset_n` low during EXEC of ADD 5:
  - No `rsp_valid`; `acc`=0.
  - After release, a pending MOV 3 is accepted on the first edge and yields `acc`=3.
